gray_stream_checker: RTL and testbench
======================================

Name: gray_stream_checker

Overview:
- Downstream consumer of an 8-bit binary-to-Gray encoder stream.
- Accepts Gray-coded samples over a valid/ready handshake and decodes each one back to binary.
- Checks that consecutive samples are adjacent (±1 mod 2^WIDTH) and flags any that are not.
- Keeps a saturating error count; used as an on-chip monitor for Gray-coded position and pointer buses.

Parameters:
- WIDTH, 8, width of Gray input and binary output.
- ERR_CNT_W, 8, width of the saturating error counter.
- ALLOW_REPEAT, 0, 1 = an identical consecutive sample is legal; 0 = it is an error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear: flush output, unlock, zero err_count.
- in_valid  input  1  gray_in is valid.
- in_ready  output  1  block can accept a sample this cycle.
- gray_in  input  WIDTH  Gray-coded sample.
- out_valid  output  1  bin_out, step_err and dir_up are valid.
- out_ready  input  1  downstream accepts the output.
- bin_out  output  WIDTH  decoded binary value.
- step_err  output  1  this sample is non-adjacent to the previous one.
- dir_up  output  1  1 = previous+1 (or first sample), 0 = previous-1.
- err_count  output  ERR_CNT_W  saturating count of step errors.
- locked  output  1  a reference sample is held; checking is active.

Behaviour:
- Handshake and timing
  - Accept occurs when in_valid && in_ready.
  - in_ready = !clear && (!out_valid || out_ready), combinational. This gives one-deep output buffering and full throughput with no bubbles.
  - Latency: sample accepted in cycle N appears with out_valid=1 in cycle N+1.
  - out_valid, bin_out, step_err and dir_up hold stable while out_valid && !out_ready.
  - out_valid drops when out_ready is high and there is no new accept.
- Decode
  - bin[WIDTH-1] = g[WIDTH-1].
  - bin[i] = bin[i+1] ^ g[i], for i descending.
  - Implemented combinationally on gray_in; the result is registered on accept.
- FSM, two states
  - UNLOCKED (reset state). On accept: store decoded value as prev; step_err=0; dir_up=1; go to LOCKED. No check is made.
  - LOCKED. On accept, with b = decoded value:
    - b == prev+1 mod 2^WIDTH: step_err=0, dir_up=1.
    - b == prev-1 mod 2^WIDTH: step_err=0, dir_up=0.
    - b == prev: step_err = !ALLOW_REPEAT; dir_up keeps its previous value.
    - Anything else: step_err=1, dir_up=0.
    - prev is always updated to b, so resynchronisation happens after one bad sample.
  - locked = (state == LOCKED).
- Wrap-around: prev = 2^WIDTH-1 followed by 0 is a legal up-step; 0 followed by 2^WIDTH-1 is a legal down-step.
- err_count
  - Increments by 1 on each accepted sample with step_err=1.
  - Saturates at 2^ERR_CNT_W-1; never wraps.
- clear
  - Next cycle: out_valid=0, state=UNLOCKED, err_count=0, step_err=0.
  - The input is not accepted during a clear cycle (in_ready=0), so clear takes priority over a simultaneous accept.
  - An output pending at clear is discarded.
- Reset
  - Values: out_valid=0, bin_out=0, step_err=0, dir_up=0, err_count=0, locked=0, prev=0.
  - Reset mid-stream discards any pending output; the first sample after reset is never flagged.
  - rst has priority over clear.

Decomposition:
- Shared package gray_pkg holds:
  - GRAY_W default constant (8).
  - The state enum type {UNLOCKED, LOCKED}.
  - A gray2bin function for benches and reference models.
- One combinational sub-module, gray_to_binary (parameter WIDTH): the inverse of the existing encoder, instantiated once for gray_in.
- All sequential logic stays in gray_stream_checker.

Test Plan:
- Reset, then stream Gray 00,01,03,02,06,07 with out_ready=1 → bin_out 0,1,2,3,4,5 on consecutive cycles; step_err=0; dir_up=1 from the second output; locked=1 after the first accept; err_count=0.
- Wrap: Gray 0x80 (bin 255), then 0x00, then 0x80 → bin 255,0,255; no errors; dir_up 1 then 0.
- Jump: Gray 0x02 (bin 3), then 0x05 (bin 6), then 0x04 (bin 7) → step_err=1 only on 6; err_count=1; 7 is accepted as a legal up-step.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0; outputs held stable; no sample lost. On release, the next sample appears the cycle after accept.
- Saturation/repeat: ERR_CNT_W=2, ALLOW_REPEAT=0, feed 5 repeated identical samples after the first → err_count reaches 3 and stays 3. With ALLOW_REPEAT=1 → err_count=0.
- clear and rst mid-stream: assert clear together with in_valid → sample not accepted; next cycle out_valid=0, err_count=0, locked=0; the next sample is unflagged. The same sequence with rst gives all outputs at reset values.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-stream checker: default width, FSM states,
// and a reference Gray-to-binary decode for benches and models.
package gray_pkg;

  localparam int GRAY_W = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder, the inverse of the upstream encoder.
module gray_to_binary #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  input  logic             unused_tie,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it; written as a
  // reduction so there is no bit-to-bit combinational chain on the vector.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/gray_stream_checker.sv
// Decodes a Gray-coded valid/ready stream, flags non-adjacent consecutive
// samples, and keeps a saturating error count.
module gray_stream_checker
  import gray_pkg::*;
#(
  parameter int WIDTH        = GRAY_W,
  parameter int ERR_CNT_W    = 8,
  parameter bit ALLOW_REPEAT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     gray_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_err,
  output logic                 dir_up,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  localparam logic [WIDTH-1:0]     ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t           state_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;
  logic             accept;
  logic             step_err_next;
  logic             dir_up_next;

  gray_to_binary #(.WIDTH(WIDTH)) u_dec (
    .gray       (gray_in),
    .unused_tie (1'b0),
    .bin        (dec)
  );

  // One-deep output stage: accept whenever the slot is empty or draining.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign locked   = (state_reg == LOCKED);
  assign prev_inc = prev_reg + ONE;
  assign prev_dec = prev_reg - ONE;

  always_comb begin
    step_err_next = 1'b0;
    dir_up_next   = 1'b1;
    if (state_reg == LOCKED) begin
      if (dec == prev_inc) begin
        step_err_next = 1'b0;
        dir_up_next   = 1'b1;
      end else if (dec == prev_dec) begin
        step_err_next = 1'b0;
        dir_up_next   = 1'b0;
      end else if (dec == prev_reg) begin
        step_err_next = !ALLOW_REPEAT;
        dir_up_next   = dir_up;
      end else begin
        step_err_next = 1'b1;
        dir_up_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= UNLOCKED;
      prev_reg  <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      step_err  <= 1'b0;
      dir_up    <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      state_reg <= UNLOCKED;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      state_reg <= LOCKED;
      prev_reg  <= dec;
      out_valid <= 1'b1;
      bin_out   <= dec;
      step_err  <= step_err_next;
      dir_up    <= dir_up_next;
      if (step_err_next && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_ONE;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_stream_checker.sv
// Directed bench for gray_stream_checker: streaming, wrap, jump, backpressure,
// counter saturation/repeat handling, and clear/reset mid-stream.
module tb_gray_stream_checker;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, out_ready;
  logic [7:0] gray_in;

  logic       in_ready, out_valid, step_err, dir_up, locked;
  logic [7:0] bin_out, err_count;

  logic       s_in_ready, s_out_valid, s_step_err, s_dir_up, s_locked;
  logic [7:0] s_bin_out;
  logic [1:0] s_err_count;

  logic       r_in_ready, r_out_valid, r_step_err, r_dir_up, r_locked;
  logic [7:0] r_bin_out;
  logic [1:0] r_err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_stream_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out),
    .step_err(step_err), .dir_up(dir_up), .err_count(err_count), .locked(locked)
  );

  gray_stream_checker #(.WIDTH(8), .ERR_CNT_W(2), .ALLOW_REPEAT(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .gray_in(gray_in), .out_valid(s_out_valid), .out_ready(out_ready), .bin_out(s_bin_out),
    .step_err(s_step_err), .dir_up(s_dir_up), .err_count(s_err_count), .locked(s_locked)
  );

  gray_stream_checker #(.WIDTH(8), .ERR_CNT_W(2), .ALLOW_REPEAT(1'b1)) dut_rep (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(r_in_ready),
    .gray_in(gray_in), .out_valid(r_out_valid), .out_ready(out_ready), .bin_out(r_bin_out),
    .step_err(r_step_err), .dir_up(r_dir_up), .err_count(r_err_count), .locked(r_locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full output bundle of the main instance after a transaction.
  task automatic expect_out(input string tag, input logic [7:0] b, input logic e,
                            input logic d, input logic [7:0] c, input logic l);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".bin"}, 32'(bin_out), 32'(b));
    check({tag, ".err"}, 32'(step_err), 32'(e));
    check({tag, ".dir"}, 32'(dir_up), 32'(d));
    check({tag, ".cnt"}, 32'(err_count), 32'(c));
    check({tag, ".lock"}, 32'(locked), 32'(l));
    $display("txn %-10s gray=%02h bin=%02h err=%0d dir=%0d cnt=%0d lock=%0d",
             tag, gray_in, bin_out, step_err, dir_up, err_count, locked);
  endtask

  task automatic send(input logic [7:0] g);
    in_valid = 1'b1;
    gray_in  = g;
    tick();
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.valid", 32'(out_valid), 32'd0);
    check("clr.lock", 32'(locked), 32'd0);
    check("clr.cnt", 32'(err_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; gray_in = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.bin", 32'(bin_out), 32'd0);
    check("rst.err", 32'(step_err), 32'd0);
    check("rst.dir", 32'(dir_up), 32'd0);
    check("rst.cnt", 32'(err_count), 32'd0);
    check("rst.lock", 32'(locked), 32'd0);
    check("rst.rdy", 32'(in_ready), 32'd1);

    // Counting stream 0..5.
    send(8'h00); expect_out("s0", 8'd0, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h01); expect_out("s1", 8'd1, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h03); expect_out("s2", 8'd2, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h02); expect_out("s3", 8'd3, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h06); expect_out("s4", 8'd4, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h07); expect_out("s5", 8'd5, 1'b0, 1'b1, 8'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Wrap-around in both directions.
    do_clear();
    send(8'h80); expect_out("w255", 8'd255, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h00); expect_out("w0", 8'd0, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h80); expect_out("w255b", 8'd255, 1'b0, 1'b0, 8'd0, 1'b1);

    // Jump 3 -> 6 is flagged, 6 -> 7 resynchronises.
    do_clear();
    send(8'h02); expect_out("j3", 8'd3, 1'b0, 1'b1, 8'd0, 1'b1);
    send(8'h05); expect_out("j6", 8'd6, 1'b1, 1'b0, 8'd1, 1'b1);
    send(8'h04); expect_out("j7", 8'd7, 1'b0, 1'b1, 8'd1, 1'b1);

    // Backpressure: output held, input stalled, nothing lost.
    send(8'h0C); expect_out("bp8", 8'd8, 1'b0, 1'b1, 8'd1, 1'b1);
    out_ready = 1'b0;
    gray_in   = 8'h0D;
    #1;
    check("bp.rdy0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.rdy", 32'(in_ready), 32'd0);
      expect_out("bp.hold", 8'd8, 1'b0, 1'b1, 8'd1, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("bp.rdy1", 32'(in_ready), 32'd1);
    tick();
    expect_out("bp9", 8'd9, 1'b0, 1'b1, 8'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    check("bp.drain", 32'(out_valid), 32'd0);

    // Repeats: wide counter counts, 2-bit counter saturates, repeat-allowed stays 0.
    do_clear();
    send(8'h05);
    check("rep.first.err", 32'(step_err), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send(8'h05);
      check("rep.cnt", 32'(err_count), 32'(i));
      check("rep.sat", 32'(s_err_count), (i < 3) ? 32'(i) : 32'd3);
      check("rep.allow", 32'(r_err_count), 32'd0);
      check("rep.allow.err", 32'(r_step_err), 32'd0);
      $display("txn rep%0d     cnt=%0d sat=%0d allow=%0d", i, err_count, s_err_count, r_err_count);
    end

    // Clear with a simultaneous sample: not accepted, then next sample unflagged.
    clear    = 1'b1;
    in_valid = 1'b1;
    gray_in  = 8'h06;
    #1;
    check("clr.rdy", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0;
    check("clrm.valid", 32'(out_valid), 32'd0);
    check("clrm.lock", 32'(locked), 32'd0);
    check("clrm.cnt", 32'(err_count), 32'd0);
    check("clrm.err", 32'(step_err), 32'd0);
    check("clrm.sat", 32'(s_err_count), 32'd0);
    tick();
    expect_out("clr.next", 8'd4, 1'b0, 1'b1, 8'd0, 1'b1);

    // Reset mid-stream, asserted together with clear and a sample.
    send(8'h00); expect_out("pre.rst", 8'd0, 1'b1, 1'b0, 8'd1, 1'b1);
    rst     = 1'b1;
    clear   = 1'b1;
    gray_in = 8'h0F;
    tick();
    rst   = 1'b0;
    clear = 1'b0;
    check("rstm.valid", 32'(out_valid), 32'd0);
    check("rstm.bin", 32'(bin_out), 32'd0);
    check("rstm.err", 32'(step_err), 32'd0);
    check("rstm.dir", 32'(dir_up), 32'd0);
    check("rstm.cnt", 32'(err_count), 32'd0);
    check("rstm.lock", 32'(locked), 32'd0);
    tick();
    expect_out("rst.next", 8'd10, 1'b0, 1'b1, 8'd0, 1'b1);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
